// File: rtl/axi4_lite_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_master
//
// Purpose
//   AXI4-Lite initiator. A simple single-beat request/response port (CPU LSU
//   or DMA side) is turned into AXI4-Lite write (AW/W/B) or read (AR/R)
//   transactions. Only one transaction is in flight at a time. Every AXI and
//   response output comes straight from a flop. No slave input reaches an
//   output through combinational logic.
//
// Parameters
//   DATA_W  data width in bits (multiple of 8); strobe width is DATA_W/8
//   ADDR_W  byte-address width
//
// Ports
//   ACLK, ARESET            clock, synchronous active-high reset
//   REQ_VALID/REQ_READY     request handshake (REQ_READY high only when idle)
//   REQ_WE                  1 = write, 0 = read
//   REQ_ADDR/WDATA/WSTRB    request payload, latched on accept
//   RSP_VALID               one-cycle completion pulse (cannot be stalled)
//   RSP_RDATA               read data of the last completed read
//   RSP_ERR                 last completion had a non-OKAY response
//   AW_*, W_*, B_*          AXI4-Lite write channels
//   AR_*, R_*               AXI4-Lite read channels
// ---------------------------------------------------------------------------
module axi4_lite_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // request / response port
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_W-1:0]     REQ_ADDR,
  input  logic [DATA_W-1:0]     REQ_WDATA,
  input  logic [DATA_W/8-1:0]   REQ_WSTRB,
  output logic                  RSP_VALID,
  output logic [DATA_W-1:0]     RSP_RDATA,
  output logic                  RSP_ERR,
  // write address channel
  output logic                  AW_VALID,
  input  logic                  AW_READY,
  output logic [ADDR_W-1:0]     AW_ADDR,
  // write data channel
  output logic                  W_VALID,
  input  logic                  W_READY,
  output logic [DATA_W-1:0]     W_DATA,
  output logic [DATA_W/8-1:0]   W_STRB,
  // write response channel
  input  logic                  B_VALID,
  output logic                  B_READY,
  input  logic [1:0]            B_RESP,
  // read address channel
  output logic                  AR_VALID,
  input  logic                  AR_READY,
  output logic [ADDR_W-1:0]     AR_ADDR,
  // read data channel
  input  logic                  R_VALID,
  output logic                  R_READY,
  input  logic [DATA_W-1:0]     R_DATA,
  input  logic [1:0]            R_RESP
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_R = 3'd4,
    RSP  = 3'd5
  } state_t;

  state_t              state_reg;
  logic                req_ready_reg;
  logic                aw_valid_reg;
  logic                w_valid_reg;
  logic                b_ready_reg;
  logic                ar_valid_reg;
  logic                r_ready_reg;
  logic                rsp_valid_reg;
  logic                rsp_err_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic [ADDR_W-1:0]   aw_addr_reg;
  logic [ADDR_W-1:0]   ar_addr_reg;
  logic [DATA_W-1:0]   w_data_reg;
  logic [STRB_W-1:0]   w_strb_reg;
  // Set once the matching write channel has finished its handshake in WR.
  logic                aw_done_reg;
  logic                w_done_reg;

  // Handshakes. Each one is qualified by the registered VALID/READY, so a
  // stray READY or VALID from the slave outside its phase has no effect.
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic aw_fin;
  logic w_fin;

  always_comb begin
    aw_hs  = aw_valid_reg & AW_READY;
    w_hs   = w_valid_reg  & W_READY;
    b_hs   = b_ready_reg  & B_VALID;
    ar_hs  = ar_valid_reg & AR_READY;
    r_hs   = r_ready_reg  & R_VALID;
    // A channel counts as done if it finished earlier or is finishing now.
    // This lets AW and W complete in either order or in the same cycle.
    aw_fin = aw_done_reg | aw_hs;
    w_fin  = w_done_reg  | w_hs;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      aw_valid_reg  <= 1'b0;
      w_valid_reg   <= 1'b0;
      b_ready_reg   <= 1'b0;
      ar_valid_reg  <= 1'b0;
      r_ready_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      aw_addr_reg   <= '0;
      ar_addr_reg   <= '0;
      w_data_reg    <= '0;
      w_strb_reg    <= '0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (REQ_VALID && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            if (REQ_WE) begin
              // Both write channels are raised together on the edge after
              // accept. The payload is fixed until the next accept.
              aw_addr_reg  <= REQ_ADDR;
              w_data_reg   <= REQ_WDATA;
              w_strb_reg   <= REQ_WSTRB;
              aw_valid_reg <= 1'b1;
              w_valid_reg  <= 1'b1;
              aw_done_reg  <= 1'b0;
              w_done_reg   <= 1'b0;
              state_reg    <= WR;
            end else begin
              ar_addr_reg  <= REQ_ADDR;
              ar_valid_reg <= 1'b1;
              state_reg    <= RD_A;
            end
          end
        end

        WR: begin
          if (aw_hs) begin
            aw_valid_reg <= 1'b0;
            aw_done_reg  <= 1'b1;
          end
          if (w_hs) begin
            w_valid_reg <= 1'b0;
            w_done_reg  <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            b_ready_reg <= 1'b1;
            state_reg   <= WR_B;
          end
        end

        WR_B: begin
          if (b_hs) begin
            b_ready_reg   <= 1'b0;
            rsp_err_reg   <= (B_RESP != 2'b00);
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end
        end

        RD_A: begin
          if (ar_hs) begin
            ar_valid_reg <= 1'b0;
            r_ready_reg  <= 1'b1;
            state_reg    <= RD_R;
          end
        end

        RD_R: begin
          if (r_hs) begin
            r_ready_reg   <= 1'b0;
            rsp_rdata_reg <= R_DATA;
            rsp_err_reg   <= (R_RESP != 2'b00);
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end
        end

        RSP: begin
          // The completion pulse lasts exactly one cycle. RSP_RDATA and
          // RSP_ERR keep their values until the next completion.
          rsp_valid_reg <= 1'b0;
          req_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          aw_valid_reg  <= 1'b0;
          w_valid_reg   <= 1'b0;
          b_ready_reg   <= 1'b0;
          ar_valid_reg  <= 1'b0;
          r_ready_reg   <= 1'b0;
          rsp_valid_reg <= 1'b0;
          aw_done_reg   <= 1'b0;
          w_done_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_READY = req_ready_reg;
  assign RSP_VALID = rsp_valid_reg;
  assign RSP_RDATA = rsp_rdata_reg;
  assign RSP_ERR   = rsp_err_reg;
  assign AW_VALID  = aw_valid_reg;
  assign AW_ADDR   = aw_addr_reg;
  assign W_VALID   = w_valid_reg;
  assign W_DATA    = w_data_reg;
  assign W_STRB    = w_strb_reg;
  assign B_READY   = b_ready_reg;
  assign AR_VALID  = ar_valid_reg;
  assign AR_ADDR   = ar_addr_reg;
  assign R_READY   = r_ready_reg;

endmodule

// File: tb/tb_axi4_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_master
//
// Directed bench for axi4_lite_master. A small AXI4-Lite slave model with a
// 16-word memory sits behind the DUT. The slave has programmable ready stalls,
// read latency and response codes. The bench also keeps watch on the AXI
// channels and counts protocol slips: a VALID that drops before its
// handshake, a payload that changes while VALID is high, and B_READY raised
// while a write channel is still open.
// ---------------------------------------------------------------------------
module tb_axi4_lite_master;

  logic        ACLK;
  logic        ARESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [3:0]  REQ_WSTRB;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        AW_VALID;
  logic        AW_READY;
  logic [31:0] AW_ADDR;
  logic        W_VALID;
  logic        W_READY;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        B_VALID;
  logic        B_READY;
  logic [1:0]  B_RESP;
  logic        AR_VALID;
  logic        AR_READY;
  logic [31:0] AR_ADDR;
  logic        R_VALID;
  logic        R_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;

  axi4_lite_master #(.DATA_W(32), .ADDR_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic [31:0] mem [0:15];
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic        r_override = 1'b0;
  logic [31:0] r_data_cfg = 32'h0;

  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic        have_aw, have_w, s_bvalid, s_rvalid, r_pend;
  logic [31:0] s_awaddr, s_wdata, s_rdata, r_addr;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;

  assign AW_READY = !have_aw && (aw_cnt >= aw_lat);
  assign W_READY  = !have_w  && (w_cnt  >= w_lat);
  assign AR_READY = (ar_cnt >= ar_lat);
  assign B_VALID  = s_bvalid;
  assign B_RESP   = s_bresp;
  assign R_VALID  = s_rvalid;
  assign R_DATA   = s_rdata;
  assign R_RESP   = s_rresp;

  logic        aw_ok, w_ok;
  logic [31:0] eff_awaddr, eff_wdata;
  logic [3:0]  eff_wstrb;
  assign aw_ok      = have_aw || (AW_VALID && AW_READY);
  assign w_ok       = have_w  || (W_VALID && W_READY);
  assign eff_awaddr = have_aw ? s_awaddr : AW_ADDR;
  assign eff_wdata  = have_w  ? s_wdata  : W_DATA;
  assign eff_wstrb  = have_w  ? s_wstrb  : W_STRB;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      r_pend <= 1'b0; s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0; r_addr <= '0;
    end else begin
      if (AW_VALID && !AW_READY) aw_cnt <= aw_cnt + 1;
      else if (AW_VALID && AW_READY) aw_cnt <= 0;
      if (W_VALID && !W_READY) w_cnt <= w_cnt + 1;
      else if (W_VALID && W_READY) w_cnt <= 0;
      if (AR_VALID && !AR_READY) ar_cnt <= ar_cnt + 1;
      else if (AR_VALID && AR_READY) ar_cnt <= 0;

      if (aw_ok && w_ok && !s_bvalid) begin
        mem[eff_awaddr[5:2]] <= merge(mem[eff_awaddr[5:2]], eff_wdata, eff_wstrb);
        s_bvalid <= 1'b1;
        s_bresp  <= b_resp_cfg;
        have_aw  <= 1'b0;
        have_w   <= 1'b0;
      end else begin
        if (AW_VALID && AW_READY) begin have_aw <= 1'b1; s_awaddr <= AW_ADDR; end
        if (W_VALID && W_READY) begin have_w <= 1'b1; s_wdata <= W_DATA; s_wstrb <= W_STRB; end
      end
      if (s_bvalid && B_READY) s_bvalid <= 1'b0;

      if (AR_VALID && AR_READY) begin
        if (r_lat == 0) begin
          s_rvalid <= 1'b1;
          s_rdata  <= r_override ? r_data_cfg : mem[AR_ADDR[5:2]];
          s_rresp  <= r_resp_cfg;
        end else begin
          r_pend <= 1'b1;
          r_cnt  <= 1;
          r_addr <= AR_ADDR;
        end
      end else if (r_pend) begin
        if (r_cnt >= r_lat) begin
          r_pend   <= 1'b0;
          s_rvalid <= 1'b1;
          s_rdata  <= r_override ? r_data_cfg : mem[r_addr[5:2]];
          s_rresp  <= r_resp_cfg;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (s_rvalid && R_READY) s_rvalid <= 1'b0;
    end
  end

  // ---------------- channel watcher ----------------
  int          aw_cyc_cnt = 0, w_cyc_cnt = 0, rsp_cnt = 0, proto_err = 0;
  int          aw_rise = 0, ar_rise = 0;
  logic        prev_awv = 1'b0, prev_arv = 1'b0;
  logic        pa_aw = 1'b0, pa_w = 1'b0, pa_ar = 1'b0;
  logic [31:0] pa_awaddr = '0, pa_wdata = '0, pa_araddr = '0;
  logic [3:0]  pa_wstrb = '0;

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (pa_aw && (!AW_VALID || AW_ADDR != pa_awaddr)) proto_err++;
      if (pa_w && (!W_VALID || W_DATA != pa_wdata || W_STRB != pa_wstrb)) proto_err++;
      if (pa_ar && (!AR_VALID || AR_ADDR != pa_araddr)) proto_err++;
      if (B_READY && (AW_VALID || W_VALID)) proto_err++;
    end
    if (AW_VALID) aw_cyc_cnt++;
    if (W_VALID) w_cyc_cnt++;
    if (RSP_VALID) rsp_cnt++;
    if (AW_VALID && !prev_awv) aw_rise = cyc;
    if (AR_VALID && !prev_arv) ar_rise = cyc;
    prev_awv  = AW_VALID;
    prev_arv  = AR_VALID;
    pa_aw     = AW_VALID && !AW_READY && !ARESET;
    pa_w      = W_VALID && !W_READY && !ARESET;
    pa_ar     = AR_VALID && !AR_READY && !ARESET;
    pa_awaddr = AW_ADDR;
    pa_wdata  = W_DATA;
    pa_wstrb  = W_STRB;
    pa_araddr = AR_ADDR;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  // Results of the most recent do_req
  int          acc_cyc, rsp_cyc, b_aw, b_w, b_rsp, b_proto;
  logic [31:0] rsp_data;
  logic        rsp_err, busy_ready, ready_after, rsp_after;

  // Issue one request and wait for its completion. The call must be made just
  // after a falling edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
    int n;
    b_aw = aw_cyc_cnt; b_w = w_cyc_cnt; b_rsp = rsp_cnt; b_proto = proto_err;
    REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_WSTRB = strb; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 50) begin tick(); n++; end
    chk("req_accept", {31'd0, REQ_READY}, 32'd1);
    acc_cyc = cyc;
    tick();
    REQ_VALID  = 1'b0;
    busy_ready = REQ_READY;
    n = 0;
    while (!RSP_VALID && n < 100) begin tick(); n++; end
    chk("rsp_seen", {31'd0, RSP_VALID}, 32'd1);
    rsp_cyc  = cyc;
    rsp_data = RSP_RDATA;
    rsp_err  = RSP_ERR;
    tick();
    ready_after = REQ_READY;
    rsp_after   = RSP_VALID;
    $display("txn we=%0d addr=0x%08h wdata=0x%08h strb=%h -> rdata=0x%08h err=%0d lat=%0d",
             we, addr, wdata, strb, rsp_data, rsp_err, rsp_cyc - acc_cyc);
  endtask

  initial begin
    int n;
    int acc_prev;
    ARESET = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0;
    REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
    repeat (3) tick();
    ARESET = 1'b0;
    tick();

    // Reset values
    chk("rst_req_ready", {31'd0, REQ_READY}, 32'd1);
    chk("rst_aw_valid",  {31'd0, AW_VALID},  32'd0);
    chk("rst_w_valid",   {31'd0, W_VALID},   32'd0);
    chk("rst_b_ready",   {31'd0, B_READY},   32'd0);
    chk("rst_ar_valid",  {31'd0, AR_VALID},  32'd0);
    chk("rst_r_ready",   {31'd0, R_READY},   32'd0);
    chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("rst_rsp_err",   {31'd0, RSP_ERR},   32'd0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
    chk("rst_aw_addr",   AW_ADDR,   32'd0);
    chk("rst_ar_addr",   AR_ADDR,   32'd0);
    chk("rst_w_data",    W_DATA,    32'd0);
    chk("rst_w_strb",    {28'd0, W_STRB}, 32'd0);

    // 1: write with a ready slave, then read back-to-back
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("t1_aw_lat",     aw_rise - acc_cyc, 32'd1);
    chk("t1_rsp_lat",    rsp_cyc - acc_cyc, 32'd3);
    chk("t1_busy_ready", {31'd0, busy_ready}, 32'd0);
    chk("t1_err",        {31'd0, rsp_err}, 32'd0);
    chk("t1_rsp_pulse",  {31'd0, rsp_after}, 32'd0);
    chk("t1_ready_c4",   {31'd0, ready_after}, 32'd1);
    acc_prev = acc_cyc;
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    chk("t1_b2b_period", acc_cyc - acc_prev, 32'd4);
    chk("t1_ar_lat",     ar_rise - acc_cyc, 32'd1);
    chk("t1_rd_lat",     rsp_cyc - acc_cyc, 32'd3);
    chk("t1_rd_data",    rsp_data, 32'hDEAD_BEEF);
    chk("t1_rd_err",     {31'd0, rsp_err}, 32'd0);

    // 2: W_READY held low for 5 cycles after AW completes
    w_lat = 5;
    do_req(1'b1, 32'h0000_0014, 32'hCAFE_0001, 4'hF);
    chk("t2_aw_cycles", aw_cyc_cnt - b_aw, 32'd1);
    chk("t2_w_cycles",  w_cyc_cnt - b_w, 32'd6);
    chk("t2_rsp_lat",   rsp_cyc - acc_cyc, 32'd8);
    tick();
    chk("t2_rsp_count", rsp_cnt - b_rsp, 32'd1);
    chk("t2_protocol",  proto_err - b_proto, 32'd0);
    w_lat = 0;

    // 3: W accepted three cycles before AW
    aw_lat = 3;
    do_req(1'b1, 32'h0000_0018, 32'h0BAD_F00D, 4'hF);
    chk("t3_w_cycles",  w_cyc_cnt - b_w, 32'd1);
    chk("t3_aw_cycles", aw_cyc_cnt - b_aw, 32'd4);
    chk("t3_rsp_lat",   rsp_cyc - acc_cyc, 32'd6);
    tick();
    chk("t3_rsp_count", rsp_cnt - b_rsp, 32'd1);
    chk("t3_protocol",  proto_err - b_proto, 32'd0);
    aw_lat = 0;
    do_req(1'b0, 32'h0000_0018, 32'h0, 4'h0);
    chk("t3_rd_data", rsp_data, 32'h0BAD_F00D);

    // 4: strobed write of one byte into an existing word
    do_req(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF);
    do_req(1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    chk("t4_rd_merge", rsp_data, 32'h1122_AB44);

    // 5: read with SLVERR, then a write with DECERR that must leave RSP_RDATA unchanged
    r_override = 1'b1; r_data_cfg = 32'h1234_5678; r_resp_cfg = 2'b10;
    do_req(1'b0, 32'h0000_0024, 32'h0, 4'h0);
    chk("t5_rd_err",  {31'd0, rsp_err}, 32'd1);
    chk("t5_rd_data", rsp_data, 32'h1234_5678);
    r_override = 1'b0; r_resp_cfg = 2'b00;
    b_resp_cfg = 2'b11;
    do_req(1'b1, 32'h0000_0028, 32'h5555_AAAA, 4'hF);
    chk("t5_wr_err",  {31'd0, rsp_err}, 32'd1);
    chk("t5_wr_keep", rsp_data, 32'h1234_5678);
    b_resp_cfg = 2'b00;
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    chk("t5_ok_clear", {31'd0, rsp_err}, 32'd0);

    // 6: reset while waiting for read data
    r_lat = 10;
    b_rsp = rsp_cnt;
    REQ_WE = 1'b0; REQ_ADDR = 32'h0000_0010; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 50) begin tick(); n++; end
    tick();
    REQ_VALID = 1'b0;
    n = 0;
    while (!R_READY && n < 20) begin tick(); n++; end
    chk("t6_in_rd_r", {31'd0, R_READY}, 32'd1);
    ARESET = 1'b1;
    tick();
    chk("t6_ar_valid",  {31'd0, AR_VALID},  32'd0);
    chk("t6_r_ready",   {31'd0, R_READY},   32'd0);
    chk("t6_req_ready", {31'd0, REQ_READY}, 32'd1);
    chk("t6_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    ARESET = 1'b0;
    r_lat = 0;
    repeat (15) tick();
    chk("t6_no_rsp", rsp_cnt - b_rsp, 32'd0);
    do_req(1'b1, 32'h0000_0030, 32'h0F0F_1234, 4'hF);
    chk("t6_wr_lat", rsp_cyc - acc_cyc, 32'd3);
    chk("t6_wr_err", {31'd0, rsp_err}, 32'd0);
    do_req(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    chk("t6_rd_data", rsp_data, 32'h0F0F_1234);

    chk("protocol_total", proto_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
